cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the arbiter, between the arbiter's line-wide physical-memory port and the 64-bit burst memory bus.
- Converts one 256-bit cache-line read or write into a 4-beat x 64-bit burst transaction.
- Presents a single-cycle done pulse back to the arbiter.
- Line-aligns addresses and holds the assembled read line stable until the next read.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory bus beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH = 4.
- ADDR_WIDTH, 32, address width; offset bits = log2(LINE_WIDTH/8) = 5.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- line_addr_i  input  ADDR_WIDTH  line request address from arbiter.
- line_read_i  input  1  line read request; held until line_resp_o.
- line_write_i  input  1  line write request; held until line_resp_o.
- line_wdata_i  input  LINE_WIDTH  line to write; sampled at acceptance.
- line_rdata_o  output  LINE_WIDTH  assembled read line.
- line_resp_o  output  1  one-cycle completion pulse.
- mem_rdata_i  input  BURST_WIDTH  read beat from memory.
- mem_resp_i  input  1  beat handshake from memory; one beat per asserted cycle.
- mem_wdata_o  output  BURST_WIDTH  write beat to memory.
- mem_addr_o  output  ADDR_WIDTH  line-aligned burst address.
- mem_read_o  output  1  burst read request.
- mem_write_o  output  1  burst write request.

Behaviour:
- States: IDLE, RD_BURST, WR_BURST, DONE. Beat counter cnt is 2 bits.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and cnt=0.
  - mem_read_o, mem_write_o and line_resp_o go to 0.
  - mem_addr_o, mem_wdata_o and line_rdata_o go to all zeros.
- IDLE:
  - On a clock edge with line_write_i=1: latch line_wdata_i and set mem_addr_o = {line_addr_i[31:5], 5'b0}. Go to WR_BURST with mem_write_o=1 and cnt=0.
  - Otherwise, with line_read_i=1: same address latch, go to RD_BURST with mem_read_o=1 and cnt=0.
  - If both requests are set, the write wins. The read is served on a later request cycle.
  - mem_resp_i is ignored in IDLE.
- RD_BURST:
  - On each edge with mem_resp_i=1: line_rdata_o[cnt*64 +: 64] <= mem_rdata_i, then cnt++.
  - Beat 0 is bits 63:0.
  - On the 4th beat (cnt==3 with resp): mem_read_o<=0, go to DONE.
  - Cycles with mem_resp_i=0 are stalls; no change.
- WR_BURST:
  - mem_wdata_o always equals latched_line[cnt*64 +: 64]. The first beat is visible the cycle mem_write_o rises.
  - On each edge with mem_resp_i=1: cnt++.
  - On the 4th beat: mem_write_o<=0, go to DONE.
- DONE:
  - line_resp_o=1 for exactly this one cycle. line_rdata_o is valid (for a read).
  - The next state is always IDLE.
  - Requests still high during DONE are not re-accepted; the requester drops them on the same edge.
- line_rdata_o holds its value after DONE. It changes only when read beats land.
- Latency with zero memory stalls:
  - Request seen at edge 0; mem_read_o/mem_write_o high from edge 0 to edge 4.
  - Beats are accepted at edges 1–4; line_resp_o is high between edges 4 and 5.
  - Total is 5 cycles request-to-resp.
- mem_addr_o is stable from acceptance through DONE. Only the line address is sent; memory increments beats internally.
- Changes to line_wdata_i or line_addr_i after acceptance have no effect.
- Reset mid-burst aborts the burst immediately; no line_resp_o is produced.

Test Plan:
- Reset: hold rst=0 mid-WR_BURST at cnt=2 -> mem_write_o=0, line_resp_o=0, state IDLE at once without a clock edge; after release the next read starts cleanly.
- Read no stalls: line_read_i=1, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_addr_o=0x0000_1220, mem_read_o high 4 cycles, line_rdata_o={0x44..,0x33..,0x22..,0x11..}, line_resp_o single pulse at cycle 5.
- Write with stalls: line_wdata_i = 256'h(D3)(D2)(D1)(D0), mem_resp_i pattern 1,0,0,1,1,0,1 -> mem_wdata_o presents D0,D1,D1,D1,D2,D3,D3. Exactly 4 beats are consumed, and line_resp_o pulses one cycle after the 4th resp.
- Simultaneous read+write at addr 0x8000_00FF -> write burst first to 0x8000_00E0. After DONE the requester re-presents the read, which completes with correct data.
- Spurious mem_resp_i=1 in IDLE for 3 cycles -> no state change, line_rdata_o unchanged, no line_resp_o.
- Back-to-back: read completes, new write asserted the cycle after line_resp_o -> accepted in IDLE, no lost or duplicated line_resp_o. line_rdata_o still holds the prior read line.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Handshake bundles on either side of the cache-line adaptor: the line-wide
// arbiter port and the beat-wide burst memory bus.

interface line_port_if #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] line_addr_i;
   logic                  line_read_i;
   logic                  line_write_i;
   logic [LINE_WIDTH-1:0] line_wdata_i;
   logic [LINE_WIDTH-1:0] line_rdata_o;
   logic                  line_resp_o;

   modport master (
      output line_addr_i, line_read_i, line_write_i, line_wdata_i,
      input  line_rdata_o, line_resp_o
   );
   modport slave (
      input  line_addr_i, line_read_i, line_write_i, line_wdata_i,
      output line_rdata_o, line_resp_o
   );
endinterface

interface burst_mem_if #(
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32
);
   logic [BURST_WIDTH-1:0] mem_rdata_i;
   logic                   mem_resp_i;
   logic [BURST_WIDTH-1:0] mem_wdata_o;
   logic [ADDR_WIDTH-1:0]  mem_addr_o;
   logic                   mem_read_o;
   logic                   mem_write_o;

   modport master (
      input  mem_rdata_i, mem_resp_i,
      output mem_wdata_o, mem_addr_o, mem_read_o, mem_write_o
   );
   modport slave (
      output mem_rdata_i, mem_resp_i,
      input  mem_wdata_o, mem_addr_o, mem_read_o, mem_write_o
   );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits one cache-line read or write into a fixed-length burst of beats and
// returns a single-cycle completion pulse to the arbiter.

module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic         clk,
   input  logic         rst,
   line_port_if.slave   line,
   burst_mem_if.master  mem
);
   localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
   localparam int CNT_W    = $clog2(BEATS);
   localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((2 ** OFFSET_W) - 1);
   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wline_q;
   logic [LINE_WIDTH-1:0] rline_q;
   logic                  read_q;
   logic                  write_q;
   logic                  resp_q;
   logic [BURST_WIDTH-1:0] wbeat [BEATS];

   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
         assign wbeat[gi] = wline_q[gi*BURST_WIDTH +: BURST_WIDTH];
      end
   endgenerate

   // Write data follows the beat counter, so beat 0 is on the bus as soon as
   // the write request rises.
   assign mem.mem_wdata_o  = wbeat[cnt_q];
   assign mem.mem_addr_o   = addr_q;
   assign mem.mem_read_o   = read_q;
   assign mem.mem_write_o  = write_q;
   assign line.line_rdata_o = rline_q;
   assign line.line_resp_o  = resp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         resp_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               // A write takes priority; a concurrent read is re-presented later.
               if (line.line_write_i) begin
                  addr_q  <= line.line_addr_i & LINE_MASK;
                  wline_q <= line.line_wdata_i;
                  write_q <= 1'b1;
                  state_q <= WR_BURST;
               end else if (line.line_read_i) begin
                  addr_q  <= line.line_addr_i & LINE_MASK;
                  read_q  <= 1'b1;
                  state_q <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (mem.mem_resp_i) begin
                  rline_q[cnt_q*BURST_WIDTH +: BURST_WIDTH] <= mem.mem_rdata_i;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) begin
                     read_q  <= 1'b0;
                     resp_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            WR_BURST: begin
               if (mem.mem_resp_i) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) begin
                     write_q <= 1'b0;
                     resp_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Exercises the cache-line adaptor against a simple burst memory that hands out
// or collects beats and records what the arbiter side observes.

module tb_cacheline_adaptor;
   localparam int LW = 256;
   localparam int BW = 64;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   line_port_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) lif ();
   burst_mem_if #(.BURST_WIDTH(BW), .ADDR_WIDTH(AW)) mif ();

   cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .clk  (clk),
      .rst  (rst),
      .line (lif),
      .mem  (mif)
   );

   int checks = 0;
   int errors = 0;
   logic [LW-1:0] exp_rline = '0;

   // Observations gathered by run_req for the scenario tasks to judge.
   int          ob_lat, ob_pulses, ob_rd_hi, ob_wr_hi, ob_wdata_bad, ob_addr_bad, ob_beats;
   logic [LW-1:0] ob_captured, ob_rdata;
   logic [AW-1:0] ob_addr_done;
   bit          ob_timeout;

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // mode 0: memory answers every cycle; 1: random stalls of pct percent;
   // 2: answers follow pat, LSB first, one bit per burst cycle.
   task automatic run_req(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wline, input logic [LW-1:0] rline,
                          input int mode, input logic [15:0] pat, input int pct,
                          input int tail);
      logic [AW-1:0] aligned;
      int  k, n, idx;
      bit  granted, want, active;
      aligned = addr & ~32'h1F;
      k = 0; n = 0; idx = 0; granted = 0;
      ob_lat = 0; ob_pulses = 0; ob_rd_hi = 0; ob_wr_hi = 0;
      ob_wdata_bad = 0; ob_addr_bad = 0; ob_timeout = 0;
      ob_captured = '0; ob_rdata = '0; ob_addr_done = '0;
      @(negedge clk);
      lif.line_addr_i  = addr;
      lif.line_wdata_i = wline;
      lif.line_read_i  = rd;
      lif.line_write_i = wr;
      while (1) begin
         @(negedge clk);
         n++;
         if (granted) k++;
         granted = 0;
         if (n == 1) begin
            lif.line_addr_i  = $urandom;
            lif.line_wdata_i = rand_line();
         end
         if (lif.line_resp_o) begin
            ob_pulses++;
            if (ob_lat == 0) begin
               ob_lat       = n;
               ob_rdata     = lif.line_rdata_o;
               ob_addr_done = mif.mem_addr_o;
            end
            lif.line_read_i  = 1'b0;
            lif.line_write_i = 1'b0;
         end
         active = mif.mem_read_o || mif.mem_write_o;
         if (mif.mem_read_o)  ob_rd_hi++;
         if (mif.mem_write_o) ob_wr_hi++;
         if (active && mif.mem_addr_o !== aligned) ob_addr_bad++;
         if (mif.mem_write_o && k < 4 && mif.mem_wdata_o !== wline[k*BW +: BW]) ob_wdata_bad++;
         if (mode == 0)      want = 1'b1;
         else if (mode == 1) want = ($urandom_range(0, 99) >= pct);
         else                want = (idx < 16) ? pat[idx] : 1'b1;
         if (active) begin
            idx++;
            granted = want && (k < 4);
         end
         mif.mem_resp_i  = granted;
         mif.mem_rdata_i = (granted && mif.mem_read_o) ? rline[k*BW +: BW] : {$urandom, $urandom};
         if (granted && mif.mem_write_o) ob_captured[k*BW +: BW] = mif.mem_wdata_o;
         if (ob_lat != 0 && n >= ob_lat + tail) break;
         if (n >= 300) begin
            ob_timeout = 1;
            break;
         end
      end
      ob_beats = k;
      mif.mem_resp_i   = 1'b0;
      lif.line_read_i  = 1'b0;
      lif.line_write_i = 1'b0;
      $display("txn rd=%0b wr=%0b addr=%h lat=%0d pulses=%0d beats=%0d timeout=%0b",
               rd, wr, addr, ob_lat, ob_pulses, ob_beats, ob_timeout);
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      logic [LW-1:0] wl, rl;
      logic [AW-1:0] ad;
      lif.line_addr_i = '0; lif.line_wdata_i = '0; lif.line_read_i = 0; lif.line_write_i = 0;
      mif.mem_rdata_i = '0; mif.mem_resp_i = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({mif.mem_read_o, mif.mem_write_o, lif.line_resp_o} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl got %b want 000", {mif.mem_read_o, mif.mem_write_o, lif.line_resp_o});
      end
      checks++;
      if (mif.mem_addr_o !== '0 || mif.mem_wdata_o !== '0 || lif.line_rdata_o !== '0) begin
         errors++; $display("FAIL reset_data addr %h wdata %h want zeros", mif.mem_addr_o, mif.mem_wdata_o);
      end
      @(negedge clk) rst = 1'b1;
      wl = rand_line();
      @(negedge clk);
      lif.line_addr_i = 32'h0000_4460; lif.line_wdata_i = wl; lif.line_write_i = 1; mif.mem_resp_i = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (mif.mem_write_o !== 1'b1 || mif.mem_wdata_o !== wl[2*BW +: BW]) begin
         errors++; $display("FAIL mid_burst_beat2 wdata %h want %h", mif.mem_wdata_o, wl[2*BW +: BW]);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({mif.mem_write_o, mif.mem_read_o, lif.line_resp_o} !== 3'b000) begin
         errors++; $display("FAIL async_abort got %b want 000", {mif.mem_write_o, mif.mem_read_o, lif.line_resp_o});
      end
      checks++;
      if (mif.mem_addr_o !== '0 || mif.mem_wdata_o !== '0) begin
         errors++; $display("FAIL async_abort_data addr %h wdata %h want zeros", mif.mem_addr_o, mif.mem_wdata_o);
      end
      lif.line_write_i = 0; mif.mem_resp_i = 0;
      @(negedge clk);
      check_int("no_resp_in_reset", int'(lif.line_resp_o), 0);
      rst = 1'b1;
      ad = $urandom; rl = rand_line();
      run_req(1, 0, ad, '0, rl, 0, '0, 0, 2);
      check_int("post_reset_lat", ob_lat, 5);
      check_int("post_reset_pulses", ob_pulses, 1);
      checks++;
      if (ob_rdata !== rl) begin
         errors++; $display("FAIL post_reset_rdata got %h want %h", ob_rdata, rl);
      end
      exp_rline = rl;
   endtask

   task automatic test_read_no_stall();
      logic [LW-1:0] rl;
      rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      run_req(1, 0, 32'h0000_1234, '0, rl, 0, '0, 0, 2);
      check_int("rd_timeout", int'(ob_timeout), 0);
      check_int("rd_lat", ob_lat, 5);
      check_int("rd_read_high", ob_rd_hi, 4);
      check_int("rd_pulses", ob_pulses, 1);
      check_int("rd_addr_bad", ob_addr_bad, 0);
      check_int("rd_addr_done", int'(ob_addr_done), 32'h0000_1220);
      checks++;
      if (ob_rdata !== rl) begin
         errors++; $display("FAIL rd_rdata got %h want %h", ob_rdata, rl);
      end
      exp_rline = rl;
   endtask

   task automatic test_write_stalls();
      logic [LW-1:0] wl;
      wl = rand_line();
      run_req(0, 1, $urandom, wl, '0, 2, 16'b0000_0000_0101_1001, 0, 2);
      check_int("wr_lat", ob_lat, 8);
      check_int("wr_write_high", ob_wr_hi, 7);
      check_int("wr_read_high", ob_rd_hi, 0);
      check_int("wr_beats", ob_beats, 4);
      check_int("wr_wdata_bad", ob_wdata_bad, 0);
      check_int("wr_pulses", ob_pulses, 1);
      checks++;
      if (ob_captured !== wl) begin
         errors++; $display("FAIL wr_captured got %h want %h", ob_captured, wl);
      end
      checks++;
      if (lif.line_rdata_o !== exp_rline) begin
         errors++; $display("FAIL wr_rdata_held got %h want %h", lif.line_rdata_o, exp_rline);
      end
   endtask

   task automatic test_simultaneous();
      logic [LW-1:0] wl, rl;
      wl = rand_line(); rl = rand_line();
      run_req(1, 1, 32'h8000_00FF, wl, rl, 1, '0, 25, 1);
      check_int("sim_read_high", ob_rd_hi, 0);
      check_int("sim_addr_done", int'(ob_addr_done), 32'h8000_00E0);
      check_int("sim_wr_pulses", ob_pulses, 1);
      checks++;
      if (ob_captured !== wl) begin
         errors++; $display("FAIL sim_captured got %h want %h", ob_captured, wl);
      end
      run_req(1, 0, 32'h8000_00FF, '0, rl, 1, '0, 25, 1);
      check_int("sim_rd_write_high", ob_wr_hi, 0);
      check_int("sim_rd_pulses", ob_pulses, 1);
      checks++;
      if (ob_rdata !== rl) begin
         errors++; $display("FAIL sim_rdata got %h want %h", ob_rdata, rl);
      end
      exp_rline = rl;
   endtask

   task automatic test_spurious_resp();
      int bad = 0;
      @(negedge clk);
      mif.mem_resp_i = 1; mif.mem_rdata_i = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (lif.line_resp_o || mif.mem_read_o || mif.mem_write_o) bad++;
         mif.mem_rdata_i = {$urandom, $urandom};
      end
      mif.mem_resp_i = 0;
      @(negedge clk);
      check_int("spurious_activity", bad, 0);
      checks++;
      if (lif.line_rdata_o !== exp_rline) begin
         errors++; $display("FAIL spurious_rdata got %h want %h", lif.line_rdata_o, exp_rline);
      end
   endtask

   task automatic test_back_to_back();
      logic [LW-1:0] wl, rl;
      wl = rand_line(); rl = rand_line();
      run_req(1, 0, $urandom, '0, rl, 0, '0, 0, 0);
      check_int("b2b_rd_pulses", ob_pulses, 1);
      checks++;
      if (ob_rdata !== rl) begin
         errors++; $display("FAIL b2b_rdata got %h want %h", ob_rdata, rl);
      end
      exp_rline = rl;
      run_req(0, 1, $urandom, wl, '0, 0, '0, 0, 2);
      check_int("b2b_wr_lat", ob_lat, 5);
      check_int("b2b_wr_pulses", ob_pulses, 1);
      checks++;
      if (ob_captured !== wl) begin
         errors++; $display("FAIL b2b_captured got %h want %h", ob_captured, wl);
      end
      checks++;
      if (lif.line_rdata_o !== exp_rline) begin
         errors++; $display("FAIL b2b_rdata_held got %h want %h", lif.line_rdata_o, exp_rline);
      end
   endtask

   task automatic test_random();
      logic [LW-1:0] wl, rl;
      bit rd, wr;
      for (int it = 0; it < 8; it++) begin
         wr = $urandom_range(0, 1);
         rd = wr ? bit'($urandom_range(0, 1)) : 1'b1;
         wl = rand_line(); rl = rand_line();
         run_req(rd, wr, $urandom, wl, rl, 1, '0, 40, 1);
         check_int("rnd_timeout", int'(ob_timeout), 0);
         check_int("rnd_pulses", ob_pulses, 1);
         check_int("rnd_addr_bad", ob_addr_bad, 0);
         check_int("rnd_beats", ob_beats, 4);
         if (wr) begin
            check_int("rnd_wdata_bad", ob_wdata_bad, 0);
            checks++;
            if (ob_captured !== wl || lif.line_rdata_o !== exp_rline) begin
               errors++; $display("FAIL rnd_write captured %h want %h", ob_captured, wl);
            end
         end else begin
            checks++;
            if (ob_rdata !== rl) begin
               errors++; $display("FAIL rnd_rdata got %h want %h", ob_rdata, rl);
            end
            exp_rline = rl;
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_no_stall();
      test_write_stalls();
      test_simultaneous();
      test_spurious_resp();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
